ahb_arbiter: RTL

- AHB bus arbiter for the shared-bus fabric.
- Consumes HBUSREQ/HLOCK from every master, including the dummy master in slot 0.
- Issues HGRANT one-hot, HMASTER (drives the address/write-data muxes) and HMASTLOCK (to slaves).
- Tracks fixed-length bursts so that ownership never changes mid-burst.

---
 rtl/ahb_arbiter_if.sv | 24 ++
 rtl/ahb_arbiter.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/ahb_arbiter_if.sv
// AHB arbitration signal bundle: master requests in, grant/ownership out.
// The arbiter connects through the slave modport; the master modport is the requesting side.
interface ahb_arbiter_if #(
   parameter int unsigned NUM_MASTERS = 3
);
   logic [NUM_MASTERS-1:0] HBUSREQ;
   logic [NUM_MASTERS-1:0] HLOCK;
   logic [1:0]             HTRANS;
   logic [2:0]             HBURST;
   logic                   HREADY;
   logic [NUM_MASTERS-1:0] HGRANT;
   logic [3:0]             HMASTER;
   logic                   HMASTLOCK;

   modport master (
      output HBUSREQ, HLOCK, HTRANS, HBURST, HREADY,
      input  HGRANT, HMASTER, HMASTLOCK
   );

   modport slave (
      input  HBUSREQ, HLOCK, HTRANS, HBURST, HREADY,
      output HGRANT, HMASTER, HMASTLOCK
   );
endinterface

// File: rtl/ahb_arbiter.sv
// AHB bus arbiter with burst tracking and locked-transfer support.
// Optional AHB_ARB_ROUND_ROBIN_EN selects rotating priority (default: fixed lowest-index).
module ahb_arbiter #(
   parameter int unsigned NUM_MASTERS    = 3,
   parameter int unsigned DEFAULT_MASTER = 0
) (
   input  logic         HCLK,
   input  logic         HRESETn,
   ahb_arbiter_if.slave bus
);

   localparam int unsigned IDX_W = 4;
   localparam int unsigned CNT_W = 4;

   localparam logic [1:0] TR_IDLE   = 2'b00;
   localparam logic [1:0] TR_BUSY   = 2'b01;
   localparam logic [1:0] TR_NONSEQ = 2'b10;
   localparam logic [1:0] TR_SEQ    = 2'b11;

   localparam logic [IDX_W-1:0]       DEF_IDX = IDX_W'(DEFAULT_MASTER);
   localparam logic [NUM_MASTERS-1:0] DEF_OH  = NUM_MASTERS'(1) << DEFAULT_MASTER;

   logic [CNT_W-1:0]       r_cnt;
   logic [IDX_W-1:0]       r_gidx;
   logic [NUM_MASTERS-1:0] r_grant;
   logic [IDX_W-1:0]       r_master;
   logic                   r_mastlock;

   logic [CNT_W-1:0]       w_burst_len;
   logic [CNT_W-1:0]       w_cnt_next;
   logic                   w_req_g;
   logic                   w_lock_g;
   logic                   w_arb_ok;
   logic [IDX_W-1:0]       w_win;
   logic [NUM_MASTERS-1:0] w_win_oh;

   // Remaining SEQ beats after a NONSEQ of each burst type
   always_comb begin
      w_burst_len = '0;
      case (bus.HBURST[2:1])
         2'b00:   w_burst_len = CNT_W'(0);
         2'b01:   w_burst_len = CNT_W'(3);
         2'b10:   w_burst_len = CNT_W'(7);
         default: w_burst_len = CNT_W'(15);
      endcase
   end

   always_comb begin
      w_cnt_next = r_cnt;
      if (bus.HREADY) begin
         case (bus.HTRANS)
            TR_IDLE:   w_cnt_next = '0;
            TR_BUSY:   w_cnt_next = r_cnt;
            TR_NONSEQ: w_cnt_next = w_burst_len;
            TR_SEQ:    w_cnt_next = (r_cnt == '0) ? '0 : r_cnt - CNT_W'(1);
            default:   w_cnt_next = r_cnt;
         endcase
      end
   end

   // Request/lock of the currently granted master, selected without a wide index
   always_comb begin
      w_req_g  = 1'b0;
      w_lock_g = 1'b0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         if (r_gidx == IDX_W'(i)) begin
            w_req_g  = bus.HBUSREQ[i];
            w_lock_g = bus.HLOCK[i];
         end
      end
   end

   assign w_arb_ok = bus.HREADY && (w_cnt_next == '0) && !(w_lock_g && w_req_g);

`ifdef AHB_ARB_ROUND_ROBIN_EN
   logic [IDX_W:0]         w_shamt;
   logic [IDX_W:0]         w_off;
   logic [IDX_W:0]         w_sum;
   logic [NUM_MASTERS-1:0] w_rot;
   logic                   w_found;

   // Rotate requests so the master after the owner sits at bit 0; owner ends up last
   always_comb begin
      w_shamt = (IDX_W+1)'(r_gidx) + (IDX_W+1)'(1);
      w_rot   = NUM_MASTERS'({bus.HBUSREQ, bus.HBUSREQ} >> w_shamt);
      w_off   = '0;
      w_found = 1'b0;
      for (int j = NUM_MASTERS - 1; j >= 0; j--) begin
         if (w_rot[j]) begin
            w_off   = (IDX_W+1)'(j);
            w_found = 1'b1;
         end
      end
      w_sum = w_shamt + w_off;
      if (w_sum >= (IDX_W+1)'(NUM_MASTERS))
         w_sum = w_sum - (IDX_W+1)'(NUM_MASTERS);
      w_win = w_found ? IDX_W'(w_sum) : DEF_IDX;
   end
`else
   // Fixed priority: lowest asserted index wins
   always_comb begin
      w_win = DEF_IDX;
      for (int j = NUM_MASTERS - 1; j >= 0; j--) begin
         if (bus.HBUSREQ[j])
            w_win = IDX_W'(j);
      end
   end
`endif

   assign w_win_oh = NUM_MASTERS'(1) << w_win;

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= w_cnt_next;
      end
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         r_gidx  <= DEF_IDX;
         r_grant <= DEF_OH;
      end else if (w_arb_ok) begin
         r_gidx  <= w_win;
         r_grant <= w_win_oh;
      end
   end

   // Address-phase ownership follows the grant on the next accepted cycle
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         r_master   <= DEF_IDX;
         r_mastlock <= 1'b0;
      end else if (bus.HREADY) begin
         r_master   <= r_gidx;
         r_mastlock <= w_lock_g;
      end
   end

   assign bus.HGRANT    = r_grant;
   assign bus.HMASTER   = r_master;
   assign bus.HMASTLOCK = r_mastlock;

endmodule
